ber_meter: RTL and testbench
============================

# ber_meter

Parametrised bit-error-rate meter with automatic reference alignment. It compares hard-decision slicer symbols against the locally generated PRBS reference. It searches all candidate channel delays for the best match, locks to one, then accumulates bit and error counts. It detects loss of lock and re-aligns. It sits after the slicer/downsampler in the receive path and is the successor to the fixed-delay, single-bit BER checker.

## Interface
- BUFFER, 16: reference history depth; candidate delays 0..BUFFER-1
- SYM_BITS, 2: bits per symbol (1 = BPSK, 2 = QPSK I/Q)
- ALIGN_LEN, 32: valid symbols per delay trial and per lock-monitor window
- LOSS_TH, 8: window error count above which lock is lost
- CNT_W, 32: width of bit and error counters
- clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global enable; low holds all state
- i_valid  in  1  symbol strobe; one symbol per high cycle
- i_clear  in  1  synchronous restart: counters and flags cleared, FSM to FILL
- i_prbs  in  SYM_BITS  reference symbol bits
- i_slicer  in  SYM_BITS  received hard-decision bits
- o_delay  out  $clog2(BUFFER)  selected delay
- o_locked  out  1  aligned and counting
- o_lost  out  1  sticky: lock was lost at least once since clear
- o_sat  out  1  counters saturated
- o_bit_cnt  out  CNT_W  bits compared while locked
- o_err_cnt  out  CNT_W  bit errors while locked

## Operation
- Symbol event = i_enable & i_valid. Nothing advances without one. Priority: i_reset > i_clear > i_enable.
- History: shift register hist[0..BUFFER-1] of i_prbs. hist[k] is the reference k symbols ago, and hist[0] is the current i_prbs. Updated every symbol event.
- Symbol errors = popcount(i_slicer ^ hist[d]), range 0..SYM_BITS.
- FSM states:
  - FILL: count BUFFER symbol events, then go to SEARCH with d=0, best_err=all-ones, best_d=0.
  - SEARCH: accumulate errors over ALIGN_LEN symbols at delay d. At trial end:
    - If the trial error is 0, lock to d immediately.
    - Else if trial < best_err, update best.
    - Ties keep the lower delay.
    - If d=BUFFER-1, lock to best_d; otherwise d+1 and start a new trial.
  - LOCK: each symbol event adds SYM_BITS to o_bit_cnt and symbol errors to o_err_cnt. A monitor accumulates errors over consecutive ALIGN_LEN-symbol windows. If a window exceeds LOSS_TH, then o_locked=0, o_lost=1, and the FSM goes to SEARCH at d=0. The history stays valid, so FILL is skipped. Counters hold their values and resume on relock.
- Saturation: if o_bit_cnt + SYM_BITS > 2^CNT_W-1, both counters freeze and o_sat=1 until clear or reset.
- i_clear: counters, o_lost, o_sat and o_locked go to 0, o_delay=0, FSM enters FILL with fill count 0.

## Timing
- Reset values: o_delay=0, o_locked=0, o_lost=0, o_sat=0, o_bit_cnt=0, o_err_cnt=0, FSM=FILL.
- All outputs are registered. Counters reflect a symbol event on the next rising edge (latency 1).
- o_locked and o_delay update on the edge that closes the deciding trial.
- The first counted symbol is the event after the lock edge.
- Minimum lock time: BUFFER + (d+1)·ALIGN_LEN symbol events for a zero-error delay d. Worst case is BUFFER + BUFFER·ALIGN_LEN.
- i_reset mid-operation: immediate return to reset values. History content is don't-care until refilled.
- i_enable low: FSM, history, counters and the monitor hold. i_valid is ignored.

## Configuration
- BER_MANUAL_DELAY_EN
  - Defined: adds ports i_manual (in, 1) and i_delay_man (in, $clog2(BUFFER)). When i_manual=1 at the end of FILL or during SEARCH, the FSM enters LOCK with o_delay=i_delay_man. Loss of lock with i_manual=1 sets o_lost but stays in LOCK.
  - Undefined: the ports are absent and the delay always comes from the search.

## Test plan
- Default params, slicer = prbs delayed 5, error-free, then 1000 symbols → o_locked after 208 events, o_delay=5, o_bit_cnt=2000, o_err_cnt=0.
- Locked at delay 3, one bit flipped every 100 symbols for 1000 symbols → o_err_cnt=10, o_bit_cnt=2000, o_locked stays 1.
- Delay 7 with one injected error during trial 7 → full search, lock after 528 events, o_delay=7.
- Locked at 3, channel changed to delay 9 → o_locked=0 within 32 symbols, o_lost=1, relock with o_delay=9, counters not cleared.
- CNT_W=8, SYM_BITS=2, error-free → o_bit_cnt freezes at 254, o_sat=1. i_clear → all outputs 0.
- i_reset pulsed mid-SEARCH → all outputs 0 asynchronously. i_enable low for 50 cycles → no output change.

Source files
------------

// File: rtl/ber_meter.sv
// ber_meter: bit-error-rate meter that compares slicer symbols with a local PRBS
// reference. It searches every candidate channel delay, locks to the best one,
// counts bits and errors, and re-aligns after loss of lock.
// Optional feature macro: BER_MANUAL_DELAY_EN adds i_manual / i_delay_man, which
// force the lock delay instead of taking it from the search.
module ber_meter #(
  parameter int BUFFER    = 16,
  parameter int SYM_BITS  = 2,
  parameter int ALIGN_LEN = 32,
  parameter int LOSS_TH   = 8,
  parameter int CNT_W     = 32
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic                       i_clear,
  input  logic [SYM_BITS-1:0]        i_prbs,
  input  logic [SYM_BITS-1:0]        i_slicer,
`ifdef BER_MANUAL_DELAY_EN
  input  logic                       i_manual,
  input  logic [$clog2(BUFFER)-1:0]  i_delay_man,
`endif
  output logic [$clog2(BUFFER)-1:0]  o_delay,
  output logic                       o_locked,
  output logic                       o_lost,
  output logic                       o_sat,
  output logic [CNT_W-1:0]           o_bit_cnt,
  output logic [CNT_W-1:0]           o_err_cnt
);

  localparam int DLY_W = $clog2(BUFFER);
  localparam int LEN_W = $clog2(ALIGN_LEN);
  localparam int ACC_W = $clog2(ALIGN_LEN * SYM_BITS + 1);
  localparam int SE_W  = $clog2(SYM_BITS + 1);

  typedef enum logic [1:0] {S_FILL, S_SEARCH, S_LOCK} state_t;

  state_t              state_q, state_d;
  logic [DLY_W-1:0]    fill_q, fill_d;
  logic [DLY_W-1:0]    try_q, try_d;
  logic [DLY_W-1:0]    best_dly_q, best_dly_d;
  logic [DLY_W-1:0]    delay_q, delay_d;
  logic [LEN_W-1:0]    len_q, len_d;        // symbol index in trial / monitor window
  logic [ACC_W-1:0]    acc_q, acc_d;        // errors in trial / monitor window
  logic [ACC_W-1:0]    best_err_q, best_err_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    err_q, err_d;

  logic [SYM_BITS-1:0] hist_q [BUFFER-1];   // hist_q[j] = reference j+1 symbols ago
  logic [SYM_BITS-1:0] hist   [BUFFER];     // hist[k]   = reference k symbols ago

  logic                sym_ev;
  logic [DLY_W-1:0]    sel;
  logic [SYM_BITS-1:0] diff;
  logic [SE_W-1:0]     sym_err;
  logic [ACC_W-1:0]    acc_sum;
  logic                win_end;
  logic [CNT_W:0]      bit_next;
  logic                man_go;
  logic [DLY_W-1:0]    man_dly;
  logic                do_lock;
  logic [DLY_W-1:0]    lock_dly;
  logic [ACC_W-1:0]    nb_err;
  logic [DLY_W-1:0]    nb_dly;

`ifdef BER_MANUAL_DELAY_EN
  assign man_go  = i_manual;
  assign man_dly = i_delay_man;
`else
  assign man_go  = 1'b0;
  assign man_dly = '0;
`endif

  assign sym_ev   = i_enable & i_valid;
  assign sel      = (state_q == S_LOCK) ? delay_q : try_q;
  assign diff     = i_slicer ^ hist[sel];
  assign acc_sum  = acc_q + ACC_W'(sym_err);
  assign win_end  = (len_q == LEN_W'(ALIGN_LEN - 1));
  assign bit_next = {1'b0, bit_q} + (CNT_W + 1)'(SYM_BITS);

  // Reference history view: tap 0 is the live input, older taps come from the register.
  always_comb begin
    hist[0] = i_prbs;
    for (int k = 1; k < BUFFER; k++) hist[k] = hist_q[k-1];
  end

  // Symbol error count: popcount of the mismatching bits.
  always_comb begin
    sym_err = '0;
    for (int b = 0; b < SYM_BITS; b++) sym_err = sym_err + SE_W'(diff[b]);
  end

  // Next-state logic for FILL / SEARCH / LOCK, counters and flags.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can leave one unassigned (no latches).
    state_d    = state_q;
    fill_d     = fill_q;
    try_d      = try_q;
    best_dly_d = best_dly_q;
    best_err_d = best_err_q;
    delay_d    = delay_q;
    len_d      = len_q;
    acc_d      = acc_q;
    locked_d   = locked_q;
    lost_d     = lost_q;
    sat_d      = sat_q;
    bit_d      = bit_q;
    err_d      = err_q;
    do_lock    = 1'b0;
    lock_dly   = '0;
    nb_err     = best_err_q;
    nb_dly     = best_dly_q;

    if (i_clear) begin
      state_d    = S_FILL;
      fill_d     = '0;
      try_d      = '0;
      best_dly_d = '0;
      best_err_d = '1;
      delay_d    = '0;
      len_d      = '0;
      acc_d      = '0;
      locked_d   = 1'b0;
      lost_d     = 1'b0;
      sat_d      = 1'b0;
      bit_d      = '0;
      err_d      = '0;
    end else if (sym_ev) begin
      unique case (state_q)
        S_FILL: begin
          if (fill_q == DLY_W'(BUFFER - 1)) begin
            fill_d     = '0;
            try_d      = '0;
            best_err_d = '1;
            best_dly_d = '0;
            len_d      = '0;
            acc_d      = '0;
            if (man_go) begin
              do_lock  = 1'b1;
              lock_dly = man_dly;
            end else begin
              state_d = S_SEARCH;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        S_SEARCH: begin
          if (man_go) begin
            do_lock  = 1'b1;
            lock_dly = man_dly;
          end else if (win_end) begin
            len_d = '0;
            acc_d = '0;
            if (acc_sum == '0) begin
              do_lock  = 1'b1;
              lock_dly = try_q;
            end else begin
              // Strict less-than keeps the lower delay on ties.
              if (acc_sum < best_err_q) begin
                nb_err = acc_sum;
                nb_dly = try_q;
              end
              best_err_d = nb_err;
              best_dly_d = nb_dly;
              if (try_q == DLY_W'(BUFFER - 1)) begin
                do_lock  = 1'b1;
                lock_dly = nb_dly;
              end else begin
                try_d = try_q + 1'b1;
              end
            end
          end else begin
            len_d = len_q + 1'b1;
            acc_d = acc_sum;
          end
        end

        S_LOCK: begin
          // Counters freeze for good once the next increment would overflow.
          if (!sat_q) begin
            if (bit_next > {1'b0, {CNT_W{1'b1}}}) begin
              sat_d = 1'b1;
            end else begin
              bit_d = bit_next[CNT_W-1:0];
              err_d = err_q + CNT_W'(sym_err);
            end
          end
          if (win_end) begin
            len_d = '0;
            acc_d = '0;
            if (acc_sum > ACC_W'(LOSS_TH)) begin
              lost_d = 1'b1;
              if (!man_go) begin
                // History is still valid, so re-search without refilling.
                state_d    = S_SEARCH;
                locked_d   = 1'b0;
                try_d      = '0;
                best_err_d = '1;
                best_dly_d = '0;
              end
            end
          end else begin
            len_d = len_q + 1'b1;
            acc_d = acc_sum;
          end
        end

        default: state_d = S_FILL;
      endcase

      if (do_lock) begin
        state_d  = S_LOCK;
        delay_d  = lock_dly;
        locked_d = 1'b1;
        len_d    = '0;
        acc_d    = '0;
      end
    end
  end

  // Control and counter registers with asynchronous reset.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_FILL;
      fill_q     <= '0;
      try_q      <= '0;
      best_dly_q <= '0;
      best_err_q <= '1;
      delay_q    <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
      sat_q      <= 1'b0;
      bit_q      <= '0;
      err_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      fill_q     <= fill_d;
      try_q      <= try_d;
      best_dly_q <= best_dly_d;
      best_err_q <= best_err_d;
      delay_q    <= delay_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
      sat_q      <= sat_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
    end
  end

  // Reference shift register, advanced on each symbol event.
  // NOTE: no reset here on purpose; the contents are don't-care until FILL has
  // refilled them, so a plain register array is enough.
  always_ff @(posedge clock) begin
    if (sym_ev) begin
      hist_q[0] <= i_prbs;
      for (int k = 1; k < BUFFER - 1; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  assign o_delay   = delay_q;
  assign o_locked  = locked_q;
  assign o_lost    = lost_q;
  assign o_sat     = sat_q;
  assign o_bit_cnt = bit_q;
  assign o_err_cnt = err_q;

endmodule

// File: tb/tb_ber_meter.sv
// tb_ber_meter: directed self-checking bench for ber_meter (default build).
// A second instance with CNT_W=8 shares the stimulus to exercise saturation.
module tb_ber_meter;

  logic        clock = 1'b0;
  logic        i_reset, i_enable, i_valid, i_clear;
  logic [1:0]  i_prbs, i_slicer;
  logic [3:0]  o_delay, s_delay;
  logic        o_locked, o_lost, o_sat, s_locked, s_lost, s_sat;
  logic [31:0] o_bit_cnt, o_err_cnt;
  logic [7:0]  s_bit_cnt, s_err_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [14:0] lfsr    = 15'h0001;
  logic [1:0]  tbh [32];          // tbh[k] = reference k symbols ago
  int          ref_dly = 0;       // delay the bench believes the DUT is locked to
  int          last_err;          // model error count for the last symbol

  always #5 clock = ~clock;

  ber_meter dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_clear(i_clear), .i_prbs(i_prbs), .i_slicer(i_slicer),
    .o_delay(o_delay), .o_locked(o_locked), .o_lost(o_lost), .o_sat(o_sat),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
  );

  ber_meter #(.CNT_W(8)) dut_sat (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_clear(i_clear), .i_prbs(i_prbs), .i_slicer(i_slicer),
    .o_delay(s_delay), .o_locked(s_locked), .o_lost(s_lost), .o_sat(s_sat),
    .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Two fresh PRBS15 bits per symbol.
  task automatic next_sym(output logic [1:0] s);
    for (int b = 0; b < 2; b++) begin
      s[b] = lfsr[14] ^ lfsr[13];
      lfsr = {lfsr[13:0], s[b]};
    end
  endtask

  // One symbol event; the channel delivers the reference dly symbols late, XOR flip.
  task automatic sym(input int dly, input logic [1:0] flip);
    logic [1:0] s;
    next_sym(s);
    for (int k = 31; k > 0; k--) tbh[k] = tbh[k-1];
    tbh[0]   = s;
    i_prbs   = s;
    i_slicer = tbh[dly] ^ flip;
    last_err = $countones(i_slicer ^ tbh[ref_dly]);
    i_enable = 1'b1;
    i_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_valid  = 1'b0;
  endtask

  // Feed symbols until o_locked rises or the budget runs out; n = events used.
  task automatic run_lock(input int dly, input int flip_at, input int max_ev, output int n);
    n = 0;
    while (n < max_ev && o_locked !== 1'b1) begin
      sym(dly, (n + 1 == flip_at) ? 2'b01 : 2'b00);
      n++;
    end
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          err_exp;
    logic        dropped;
    logic [31:0] snap_bit, snap_err;
    logic [3:0]  snap_dly;

    for (int k = 0; k < 32; k++) tbh[k] = 2'b00;
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_clear = 1'b0;
    i_prbs = 2'b00; i_slicer = 2'b00;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_delay",  o_delay,   0);
    check("rst_locked", o_locked,  0);
    check("rst_lost",   o_lost,    0);
    check("rst_sat",    o_sat,     0);
    check("rst_bits",   o_bit_cnt, 0);
    check("rst_errs",   o_err_cnt, 0);
    i_reset = 1'b0;
    @(negedge clock);

    // Error-free delay 5: 16 + 6*32 = 208 events to lock
    run_lock(5, -1, 600, n);
    check("t1_lock_evt", n, 208);
    check("t1_delay", o_delay, 5);
    check("t1_bits_at_lock", o_bit_cnt, 0);
    check("t1_sat_dut_locked", s_locked, 1);
    for (int i = 0; i < 1000; i++) begin
      sym(5, 2'b00);
      if (i == 126) begin
        check("sat_pre_bits", s_bit_cnt, 254);
        check("sat_pre_flag", s_sat, 0);
      end
      if (i == 127) check("sat_flag", s_sat, 1);
    end
    check("t1_bits", o_bit_cnt, 2000);
    check("t1_errs", o_err_cnt, 0);
    check("t1_locked", o_locked, 1);
    check("t1_sat", o_sat, 0);
    check("sat_bits_frozen", s_bit_cnt, 254);
    check("sat_errs", s_err_cnt, 0);
    check("sat_flag_held", s_sat, 1);

    // Synchronous clear
    do_clear();
    check("clr_delay",  o_delay,   0);
    check("clr_locked", o_locked,  0);
    check("clr_bits",   o_bit_cnt, 0);
    check("clr_errs",   o_err_cnt, 0);
    check("clr_sat_flag", s_sat,   0);
    check("clr_sat_bits", s_bit_cnt, 0);

    // Delay 3, one flipped bit every 100 symbols
    run_lock(3, -1, 600, n);
    check("t2_lock_evt", n, 144);
    check("t2_delay", o_delay, 3);
    dropped = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      sym(3, (i % 100 == 50) ? 2'b01 : 2'b00);
      if (o_locked !== 1'b1) dropped = 1'b1;
    end
    check("t2_errs", o_err_cnt, 10);
    check("t2_bits", o_bit_cnt, 2000);
    check("t2_never_dropped", dropped, 0);
    check("t2_lost", o_lost, 0);
    do_clear();

    // Delay 7 with one error inside trial 7 (events 241..272): full search
    run_lock(7, 250, 700, n);
    check("t3_lock_evt", n, 528);
    check("t3_delay", o_delay, 7);
    do_clear();

    // Lock at 3, channel moves to 9 on a window boundary
    run_lock(3, -1, 600, n);
    check("t4_lock_evt", n, 144);
    ref_dly = 3;
    err_exp = 0;
    for (int i = 0; i < 64; i++) begin
      sym(3, 2'b00);
      err_exp += last_err;
    end
    for (int i = 0; i < 32; i++) begin
      sym(9, 2'b00);
      err_exp += last_err;
      if (i == 30) check("t4_still_locked", o_locked, 1);
    end
    check("t4_unlocked", o_locked, 0);
    check("t4_lost", o_lost, 1);
    check("t4_bits_loss", o_bit_cnt, 192);
    check("t4_errs_loss", o_err_cnt, err_exp);
    check("t4_delay_held", o_delay, 3);
    for (int i = 0; i < 150; i++) sym(9, 2'b00);

    // Enable low for 50 cycles: nothing may change, search position holds
    snap_bit = o_bit_cnt; snap_err = o_err_cnt; snap_dly = o_delay;
    for (int i = 0; i < 50; i++) begin
      i_enable = 1'b0;
      i_valid  = 1'b1;
      i_prbs   = 2'($urandom_range(0, 3));
      i_slicer = 2'($urandom_range(0, 3));
      @(posedge clock);
      @(negedge clock);
    end
    i_valid = 1'b0;
    check("en_bits",   o_bit_cnt, snap_bit);
    check("en_errs",   o_err_cnt, snap_err);
    check("en_delay",  o_delay,   snap_dly);
    check("en_locked", o_locked,  0);
    check("en_lost",   o_lost,    1);

    // Relock at 9 after 10 trials = 320 events, 150 already spent
    run_lock(9, -1, 400, n);
    check("t4_relock_evt", n, 170);
    check("t4_relock_delay", o_delay, 9);
    check("t4_bits_kept", o_bit_cnt, 192);
    check("t4_errs_kept", o_err_cnt, err_exp);
    check("t4_lost_sticky", o_lost, 1);
    ref_dly = 9;
    for (int i = 0; i < 32; i++) sym(9, 2'b00);
    check("t4_bits_resume", o_bit_cnt, 256);
    check("t4_errs_resume", o_err_cnt, err_exp);

    // Second loss, then asynchronous reset in the middle of SEARCH
    for (int i = 0; i < 32; i++) sym(12, 2'b00);
    check("t5_unlocked", o_locked, 0);
    check("t5_bits", o_bit_cnt, 320);
    for (int i = 0; i < 40; i++) sym(12, 2'b00);
    #2 i_reset = 1'b1;
    #1;
    check("arst_delay",  o_delay,   0);
    check("arst_locked", o_locked,  0);
    check("arst_lost",   o_lost,    0);
    check("arst_sat",    o_sat,     0);
    check("arst_bits",   o_bit_cnt, 0);
    check("arst_errs",   o_err_cnt, 0);
    @(negedge clock);
    i_reset = 1'b0;

    // After reset the FSM refills: delay 4 locks after 16 + 5*32 = 176 events
    run_lock(4, -1, 400, n);
    check("t6_lock_evt", n, 176);
    check("t6_delay", o_delay, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
